// File: rtl/cvsd_pkg.sv
// cvsd_pkg: default parameters and arithmetic helpers shared by the CVSD codec.
package cvsd_pkg;

  localparam int unsigned DataWDef   = 8;
  localparam int unsigned FracWDef   = 4;
  localparam int unsigned DivDef     = 5000;
  localparam int unsigned RunDef     = 3;
  localparam int unsigned StepMinDef = 16;
  localparam int unsigned StepMaxDef = 512;
  localparam int unsigned StepIncDef = 32;
  localparam int unsigned DecayShDef = 4;
  localparam int unsigned LeakShDef  = 5;

  // Offset-binary midscale, expressed in accumulator LSBs.
  function automatic logic [31:0] mid_value(input int unsigned data_w,
                                            input int unsigned frac_w);
    mid_value = 32'd1 << (data_w - 1 + frac_w);
  endfunction

  // a +/- b clamped to [0, 2^acc_w - 1]; the 33-bit sum exposes any carry out.
  function automatic logic [31:0] sat_addsub(input logic [31:0] a, input logic [31:0] b,
                                             input logic up, input int unsigned acc_w);
    logic [32:0] lim;
    logic [32:0] sum;
    lim = (33'd1 << acc_w) - 33'd1;
    sum = {1'b0, a} + {1'b0, b};
    if (up) sat_addsub = (sum > lim) ? lim[31:0] : sum[31:0];
    else    sat_addsub = (b > a) ? 32'd0 : a - b;
  endfunction

endpackage

// File: rtl/cvsd_integrator.sv
// cvsd_integrator: run history, syllabic step adaptation and saturating accumulator.
// With CVSD_LEAK_EN defined the accumulator also leaks toward midscale on every tick.
module cvsd_integrator
  import cvsd_pkg::*;
#(
  parameter int unsigned DATA_W   = DataWDef,
  parameter int unsigned FRAC_W   = FracWDef,
  parameter int unsigned RUN      = RunDef,
  parameter int unsigned STEP_MIN = StepMinDef,
  parameter int unsigned STEP_MAX = StepMaxDef,
  parameter int unsigned STEP_INC = StepIncDef,
  parameter int unsigned DECAY_SH = DecayShDef
`ifdef CVSD_LEAK_EN
  ,
  parameter int unsigned LEAK_SH  = LeakShDef
`endif
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic              bit_i,
  output logic [DATA_W-1:0] value_o,
  output logic              coin_o
);

  localparam int unsigned      AccW    = DATA_W + FRAC_W;
  localparam int unsigned      FillW   = $clog2(RUN + 1);
  localparam logic [FillW-1:0] FillRun = FillW'(RUN);
  localparam logic [AccW-1:0]  Mid     = AccW'(mid_value(DATA_W, FRAC_W));
  localparam logic [AccW:0]    StepMin = (AccW + 1)'(STEP_MIN);
  localparam logic [AccW:0]    StepMax = (AccW + 1)'(STEP_MAX);
  localparam logic [AccW:0]    StepInc = (AccW + 1)'(STEP_INC);

  logic [RUN-1:0]   hist_q, hist_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [AccW-1:0]  step_q, step_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [AccW-1:0]  base;
  logic [AccW:0]    step_ext;
  logic [AccW:0]    decay;
  logic             coin;
`ifdef CVSD_LEAK_EN
  logic signed [AccW:0] diff;
  logic signed [AccW:0] leak;
`endif

  // Next state for one tick; only committed when tick_i is high.
  always_comb begin
    hist_d   = {hist_q[RUN-2:0], bit_i};
    fill_d   = (fill_q == FillRun) ? fill_q : fill_q + FillW'(1);
    coin     = (fill_d == FillRun) && ((hist_d == '0) || (&hist_d));
    step_ext = {1'b0, step_q};
    decay    = step_ext >> DECAY_SH;
    if (decay == '0) decay = (AccW + 1)'(1);
    if (coin) begin
      step_d = (step_ext + StepInc > StepMax) ? StepMax[AccW-1:0] : AccW'(step_ext + StepInc);
    end else begin
      step_d = (step_ext < decay + StepMin) ? StepMin[AccW-1:0] : AccW'(step_ext - decay);
    end
`ifdef CVSD_LEAK_EN
    // Pull toward midscale by a fraction of the signed offset; never overshoots.
    diff = $signed({1'b0, acc_q}) - $signed({1'b0, Mid});
    leak = diff >>> LEAK_SH;
    base = AccW'($signed({1'b0, acc_q}) - leak);
`else
    base = acc_q;
`endif
    acc_d = AccW'(sat_addsub(32'(base), 32'(step_d), bit_i, AccW));
  end

  // Integrator state advances only on a sample tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
      fill_q <= '0;
      step_q <= StepMin[AccW-1:0];
      acc_q  <= Mid;
    end else if (tick_i) begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      step_q <= step_d;
      acc_q  <= acc_d;
    end
  end

  assign value_o = acc_q[AccW-1:FRAC_W];
  assign coin_o  = coin;

endmodule

// File: rtl/cvsd_codec.sv
// cvsd_codec: CVSD encoder and decoder sharing an internal sample-tick divider.
// Optional accumulator leak is enabled by defining CVSD_LEAK_EN.
module cvsd_codec
  import cvsd_pkg::*;
#(
  parameter int unsigned DATA_W   = DataWDef,
  parameter int unsigned FRAC_W   = FracWDef,
  parameter int unsigned DIV      = DivDef,
  parameter int unsigned RUN      = RunDef,
  parameter int unsigned STEP_MIN = StepMinDef,
  parameter int unsigned STEP_MAX = StepMaxDef,
  parameter int unsigned STEP_INC = StepIncDef,
  parameter int unsigned DECAY_SH = DecayShDef
`ifdef CVSD_LEAK_EN
  ,
  parameter int unsigned LEAK_SH  = LeakShDef
`endif
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              enable,
  input  logic [DATA_W-1:0] x,
  input  logic              dec_in,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [DATA_W-1:0] xp,
  output logic              flag,
  output logic [DATA_W-1:0] y,
  output logic              y_valid
);

  localparam int unsigned     CntW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              tick;
  logic              enc_bit;
  logic              enc_coin;
  logic              dec_coin_unused;
  logic [DATA_W-1:0] enc_value;
  logic [DATA_W-1:0] dec_value;
  logic              bit_q;
  logic              valid_q;
  logic              flag_q;

  // Tick divider; dropping enable discards any partial count.
  always_comb begin
    tick = enable && (cnt_q == CntLast);
    if (!enable || tick) cnt_d = '0;
    else                 cnt_d = cnt_q + CntW'(1);
  end

  // Tie resolves upward so a constant midscale input toggles cleanly.
  assign enc_bit = (x >= enc_value);

  cvsd_integrator #(
    .DATA_W  (DATA_W),
    .FRAC_W  (FRAC_W),
    .RUN     (RUN),
    .STEP_MIN(STEP_MIN),
    .STEP_MAX(STEP_MAX),
    .STEP_INC(STEP_INC),
    .DECAY_SH(DECAY_SH)
`ifdef CVSD_LEAK_EN
    ,
    .LEAK_SH (LEAK_SH)
`endif
  ) u_enc (
    .clk_i  (CLOCK),
    .rst_ni (RESET),
    .tick_i (tick),
    .bit_i  (enc_bit),
    .value_o(enc_value),
    .coin_o (enc_coin)
  );

  cvsd_integrator #(
    .DATA_W  (DATA_W),
    .FRAC_W  (FRAC_W),
    .RUN     (RUN),
    .STEP_MIN(STEP_MIN),
    .STEP_MAX(STEP_MAX),
    .STEP_INC(STEP_INC),
    .DECAY_SH(DECAY_SH)
`ifdef CVSD_LEAK_EN
    ,
    .LEAK_SH (LEAK_SH)
`endif
  ) u_dec (
    .clk_i  (CLOCK),
    .rst_ni (RESET),
    .tick_i (tick),
    .bit_i  (dec_in),
    .value_o(dec_value),
    .coin_o (dec_coin_unused)
  );

  // Divider count and registered encoder outputs.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      cnt_q   <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= tick;
      if (tick) begin
        bit_q  <= enc_bit;
        flag_q <= enc_coin;
      end
    end
  end

  assign bit_out   = bit_q;
  assign bit_valid = valid_q;
  assign y_valid   = valid_q;
  assign flag      = flag_q;
  assign xp        = enc_value;
  assign y         = dec_value;

endmodule

// File: tb/tb_cvsd_codec.sv
// tb_cvsd_codec: table vectors, hand sequences and a reference-model scoreboard (DIV=4).
module tb_cvsd_codec;

  localparam int Div = 4;

  typedef struct {
    int acc;
    int step;
    int fill;
    int hist;
    bit coin;
  } integ_t;

  typedef struct {
    bit b;
    int xp;
    bit flag;
    int y;
  } exp_t;

  typedef struct {
    int x;
    bit b;
    int xp;
    bit flag;
  } vec_t;

  logic       CLOCK  = 1'b0;
  logic       RESET  = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] x      = 8'd128;
  logic       dec_in;
  logic       bit_out, bit_valid, flag, y_valid;
  logic [7:0] xp, y;

  int   n_vec    = 0;
  int   n_fail   = 0;
  bit   chk_loop = 1'b0;
  exp_t sb_q[$];

  assign dec_in = bit_out;

  cvsd_codec #(.DIV(Div)) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .enable   (enable),
    .x        (x),
    .dec_in   (dec_in),
    .bit_out  (bit_out),
    .bit_valid(bit_valid),
    .xp       (xp),
    .flag     (flag),
    .y        (y),
    .y_valid  (y_valid)
  );

  initial forever #5 CLOCK = ~CLOCK;

  function automatic integ_t rst_state();
    integ_t s;
    s.acc  = 2048;
    s.step = 16;
    s.fill = 0;
    s.hist = 0;
    s.coin = 1'b0;
    return s;
  endfunction

  // Reference integrator: RUN=3, STEP 16..512, INC 32, DECAY_SH 4, 12-bit accumulator.
  function automatic integ_t integ_next(integ_t s, bit b);
    integ_t n;
    int     dec;
    n      = s;
    n.hist = ((s.hist << 1) | int'(b)) & 7;
    n.fill = (s.fill < 3) ? s.fill + 1 : 3;
    n.coin = (n.fill == 3) && (n.hist == 0 || n.hist == 7);
    if (n.coin) begin
      n.step = s.step + 32;
      if (n.step > 512) n.step = 512;
    end else begin
      dec = s.step >> 4;
      if (dec < 1) dec = 1;
      n.step = s.step - dec;
      if (n.step < 16) n.step = 16;
    end
    n.acc = b ? s.acc + n.step : s.acc - n.step;
    if (n.acc > 4095) n.acc = 4095;
    if (n.acc < 0) n.acc = 0;
    return n;
  endfunction

  // Model: own divider and integrators; pushes the expected outputs on each tick.
  integ_t enc_m = rst_state();
  integ_t dec_m = rst_state();
  int     m_cnt = 0;
  bit     m_bit = 1'b0;
  initial begin
    exp_t ex;
    bit   eb;
    forever begin
      @(posedge CLOCK or negedge RESET);
      if (!RESET) begin
        m_cnt = 0;
        enc_m = rst_state();
        dec_m = rst_state();
        m_bit = 1'b0;
        sb_q.delete();
      end else if (!enable) begin
        m_cnt = 0;
      end else if (m_cnt != Div - 1) begin
        m_cnt++;
      end else begin
        m_cnt   = 0;
        eb      = (int'(x) >= (enc_m.acc >> 4));
        enc_m   = integ_next(enc_m, eb);
        dec_m   = integ_next(dec_m, m_bit);
        m_bit   = eb;
        ex.b    = eb;
        ex.xp   = enc_m.acc >> 4;
        ex.flag = enc_m.coin;
        ex.y    = dec_m.acc >> 4;
        sb_q.push_back(ex);
      end
    end
  end

  // Monitor: a pulse must appear exactly when the model expects one.
  initial begin
    exp_t       ex;
    logic [7:0] prev_xp;
    prev_xp = 8'd128;
    forever begin
      @(negedge CLOCK);
      if (RESET) begin
        if (sb_q.size() > 0) begin
          ex = sb_q.pop_front();
          n_vec++;
          if (bit_valid !== 1'b1 || y_valid !== 1'b1 || bit_out !== ex.b || xp !== 8'(ex.xp) ||
              flag !== ex.flag || y !== 8'(ex.y)) begin
            n_fail++;
            $display("FAIL scoreboard t=%0t: got v=%b/%b bit=%b xp=%0d flag=%b y=%0d, want v=1/1 bit=%b xp=%0d flag=%b y=%0d",
                     $time, bit_valid, y_valid, bit_out, xp, flag, y, ex.b, ex.xp, ex.flag, ex.y);
          end
          if (chk_loop) begin
            n_vec++;
            if (y !== prev_xp) begin
              n_fail++;
              $display("FAIL loopback t=%0t: y=%0d, expected previous xp=%0d", $time, y, prev_xp);
            end
          end
          prev_xp = xp;
        end else if (bit_valid !== 1'b0 || y_valid !== 1'b0) begin
          n_vec++;
          n_fail++;
          $display("FAIL stray_pulse t=%0t: bit_valid=%b y_valid=%b, expected 0/0",
                   $time, bit_valid, y_valid);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * Div + 4; i++) begin
      @(negedge CLOCK);
      if (bit_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic need_valid(input string name);
    bit ok;
    wait_valid(ok);
    if (!ok) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic apply_vec(input vec_t v, input string name);
    bit ok;
    x = 8'(v.x);
    wait_valid(ok);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: no bit_valid within budget", name);
    end else if (bit_out !== v.b || xp !== 8'(v.xp) || flag !== v.flag) begin
      n_fail++;
      $display("FAIL %s: got bit=%b xp=%0d flag=%b, expected bit=%b xp=%0d flag=%b",
               name, bit_out, xp, flag, v.b, v.xp, v.flag);
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    #1;
    RESET  = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge CLOCK);
    #1;
    RESET = 1'b1;
  endtask

  // {bit_out, bit_valid, flag, y_valid, xp, y} packed for one reset-state comparison.
  function automatic int out_word();
    return int'({bit_out, bit_valid, flag, y_valid, xp, y});
  endfunction

  localparam int RstWord = (128 << 8) | 128;

  vec_t t_first[3];
  vec_t t_alt[8];

  initial begin
    int  prev, d, max_drop, max_rise, min_xp, pulses, lat, xp_hold;
    bit  ok;
    t_first[0] = '{255, 1'b1, 129, 1'b0};
    t_first[1] = '{255, 1'b1, 130, 1'b0};
    t_first[2] = '{255, 1'b1, 133, 1'b1};
    for (int i = 0; i < 8; i++) t_alt[i] = '{128, (i % 2 == 0), (i % 2 == 0) ? 129 : 128, 1'b0};

    // Reset state, then the first three ticks at full-scale input.
    do_reset();
    check("reset_state", out_word(), RstWord);
    x      = 8'd255;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) apply_vec(t_first[i], $sformatf("first_tick%0d", i));

    // Asynchronous reset between ticks with step=48, then the same three ticks again.
    @(negedge CLOCK);
    #1;
    RESET = 1'b0;
    #1;
    check("reset_mid_tick", out_word(), RstWord);
    repeat (2) @(negedge CLOCK);
    #1;
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) apply_vec(t_first[i], $sformatf("after_reset_tick%0d", i));

    // Upper saturation: xp only rises and settles at 255.
    do_reset();
    x        = 8'd255;
    enable   = 1'b1;
    prev     = 128;
    max_drop = 0;
    for (int i = 0; i < 40; i++) begin
      need_valid("sat_hi");
      d = prev - int'(xp);
      if (d > max_drop) max_drop = d;
      prev = int'(xp);
      #1;
    end
    check("sat_hi_final", int'(xp), 255);
    check("sat_hi_no_drop", max_drop, 0);

    // Lower saturation: reaches 0, never jumps upward by more than one max step.
    x        = 8'd0;
    max_rise = 0;
    min_xp   = 255;
    for (int i = 0; i < 40; i++) begin
      need_valid("sat_lo");
      d = int'(xp) - prev;
      if (d > max_rise) max_rise = d;
      if (int'(xp) < min_xp) min_xp = int'(xp);
      prev = int'(xp);
      #1;
    end
    check("sat_lo_min", min_xp, 0);
    check("sat_lo_no_wrap", int'(max_rise <= 32), 1);

    // Midscale input: alternating bits at minimum step.
    do_reset();
    x      = 8'd128;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) apply_vec(t_alt[i], $sformatf("alt_tick%0d", i));

    // Enable dropped for 10 cycles: nothing moves; re-enable gives a full period.
    xp_hold = int'(xp);
    enable  = 1'b0;
    pulses  = 0;
    repeat (10) begin
      @(negedge CLOCK);
      if (bit_valid === 1'b1 || y_valid === 1'b1) pulses++;
    end
    #1;
    check("en_off_pulses", pulses, 0);
    check("en_off_xp_held", int'(xp), xp_hold);
    enable = 1'b1;
    lat    = 0;
    ok     = 1'b0;
    for (int i = 1; i <= 20 && !ok; i++) begin
      @(negedge CLOCK);
      if (bit_valid === 1'b1) begin
        ok  = 1'b1;
        lat = i;
      end
    end
    check("reenable_latency", lat, 4);
    check("reenable_step_held_xp", int'(xp), 129);
    #1;

    // Loopback: saturate both sides to a common state, then ramp 0..255.
    do_reset();
    x      = 8'd255;
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      need_valid("loop_sync");
      #1;
    end
    chk_loop = 1'b1;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      need_valid("loop_ramp");
      #1;
    end
    chk_loop = 1'b0;

    repeat (2) @(negedge CLOCK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cvsd_codec.md
Name: cvsd_codec

Overview:
- Parametrised CVSD encoder plus matching decoder in one block. Generates its own sample tick from the system clock, so the external clock divider is not needed.
- Encoder compares the input sample against its own reconstruction and emits one bit per tick. Decoder rebuilds the waveform from an incoming bit stream.
- Adaptation is syllabic: a run of RUN equal bits increases the step, otherwise the step decays. The integrator saturates and never wraps.

Parameters:
- DATA_W, 8: sample width in bits, unsigned offset-binary.
- FRAC_W, 4: fractional bits in the integrator accumulator.
- DIV, 5000: CLOCK cycles per sample tick (50 MHz to 10 kHz).
- RUN, 3: run length that counts as a coincidence.
- STEP_MIN, 16: minimum step, in accumulator LSBs.
- STEP_MAX, 512: maximum step, in accumulator LSBs.
- STEP_INC, 32: step increment applied on a coincidence.
- DECAY_SH, 4: step decay shift.
- LEAK_SH, 5: leak shift; used only with CVSD_LEAK_EN.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- enable  in  1  tick divider runs while high.
- x  in  DATA_W  encoder input sample.
- dec_in  in  1  decoder input bit.
- bit_out  out  1  encoded bit.
- bit_valid  out  1  one-cycle pulse when bit_out updates.
- xp  out  DATA_W  encoder reconstruction.
- flag  out  1  coincidence (slope overload) on the last encoder tick.
- y  out  DATA_W  decoder output.
- y_valid  out  1  one-cycle pulse when y updates.

Behaviour:
- Reset (RESET=0, asynchronous):
  - divider count = 0.
  - acc = MID = 2^(DATA_W-1) << FRAC_W, for both encoder and decoder.
  - step = STEP_MIN.
  - history and fill counter cleared.
  - bit_out, bit_valid, flag, y_valid = 0.
  - xp = y = 2^(DATA_W-1).
- Divider:
  - While enable=1, count runs 0..DIV-1; tick = (count==DIV-1).
  - While enable=0, count is forced to 0, there are no ticks and all state is held.
  - Re-enabling always gives a full DIV period before the next tick.
- Encoder, on a tick: x is sampled combinationally; all results are registered at that edge and visible one cycle later with bit_valid=1 for exactly one cycle.
  - b = (x >= xp). A tie gives 1.
  - hist <= {hist[RUN-2:0], b}. fill saturates at RUN.
  - coin = (fill_next == RUN) and all RUN bits of the new history are equal.
  - If coin: step <= min(step + STEP_INC, STEP_MAX).
  - Otherwise: step <= max(step - max(step >> DECAY_SH, 1), STEP_MIN).
  - acc <= sat(acc ± step_new), saturated to [0, 2^(DATA_W+FRAC_W) - 1].
  - xp = acc[DATA_W+FRAC_W-1:FRAC_W].
  - bit_out = b. flag = coin, held until the next tick.
- Decoder:
  - Same tick and same update rules, driven by dec_in sampled at the tick.
  - y = acc >> FRAC_W. y_valid pulses in the same cycle as bit_valid.
  - In loopback (dec_in = bit_out), y at tick n+1 equals xp from tick n.
- Arithmetic:
  - acc is unsigned DATA_W+FRAC_W bits.
  - Intermediate sums use one extra bit so saturation is detected.
  - step is DATA_W+FRAC_W bits wide.
- Reset mid-tick: all state returns to reset values immediately. The partial divider count is discarded.

Optional Feature:
- Macro: CVSD_LEAK_EN.
- Defined: on each tick, acc first moves toward MID by (acc - MID) >>> LEAK_SH (arithmetic shift, signed difference), then the step is added with saturation. Applies to both encoder and decoder.
- Undefined: pure integrator, no leak logic present.

Decomposition:
- Package cvsd_pkg: default parameter constants, the MID computation function and the saturating add/subtract function.
- Sub-module cvsd_integrator, instantiated twice (encoder, decoder):
  - Contains the history register, fill counter, step adaptation, accumulator and optional leak.
  - Inputs: tick, bit. Outputs: value, coin.
- The top level holds the divider, the comparator and the output registers.

Test Plan:
- All tests use DIV=4.
- Reset, then x=255, enable=1: first three ticks give bit_out 1,1,1; xp = 129, 130, 133; step = 16, 16, 48; flag = 0, 0, 1.
- Hold x=255 for 40 ticks: step clamps at 512; xp reaches 255 and stays there, with no wrap to 0. With x=0 instead: xp clamps at 0.
- x=128 constant: bits alternate 1,0,1,0...; xp alternates 129/128; flag stays 0; step stays 16.
- Loopback dec_in=bit_out with x a slow ramp 0→255: every y_valid has y == xp from the previous tick; y_valid coincides with bit_valid.
- enable dropped for 10 cycles mid-run: no valid pulses; xp and step unchanged; the first tick after re-enable comes exactly 4 cycles later.
- RESET asserted between ticks with step=48: outputs return to reset values before the next edge; after release, the first tick behaves exactly as in the first test.
